mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the CPU's instruction-fetch (IFU) and load/store (LSU) requesters.
- Sits between the cpu core and the SoC memory/bus interface, which exposes a single req/resp channel.
- Allows one outstanding transaction at a time.
- Applies a selectable priority policy and a response watchdog that returns an error instead of hanging the core.

Parameters:
- LSU_FIRST, 1: when 1, LSU wins simultaneous requests; when 0, grants alternate round-robin starting with IFU.
- TIMEOUT_CYCLES, 1024: cycles in BUSY without io_mem_respValid before a timeout error response; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0000: rdata returned on a timeout response.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_ifu_reqValid  in  1  IFU request
- io_ifu_addr  in  32  fetch address
- io_ifu_respValid  out  1  IFU response pulse
- io_ifu_rdata  out  32  fetched word
- io_ifu_err  out  1  IFU response is a timeout error
- io_lsu_reqValid  in  1  LSU request
- io_lsu_addr  in  32  LSU address
- io_lsu_size  in  2  0=byte, 1=half, 2=word
- io_lsu_wen  in  1  write enable
- io_lsu_wdata  in  32  write data
- io_lsu_wmask  in  4  byte mask
- io_lsu_respValid  out  1  LSU response pulse
- io_lsu_rdata  out  32  load data
- io_lsu_err  out  1  LSU response is a timeout error
- io_mem_reqValid  out  1  downstream request
- io_mem_addr  out  32  downstream address
- io_mem_size  out  2  downstream size
- io_mem_wen  out  1  downstream write enable
- io_mem_wdata  out  32  downstream write data
- io_mem_wmask  out  4  downstream byte mask
- io_mem_respValid  in  1  downstream response
- io_mem_rdata  in  32  downstream read data

Behaviour:
- Reset: state=IDLE; all io_mem_* outputs, respValid, rdata and err outputs are 0; rr_last=LSU, so IFU is granted first under round-robin; timeout counter=0.
- Requester contract: reqValid and its fields are held stable until that requester's respValid. The respValid cycle consumes the request. reqValid still high in the following cycle is a new request.
- FSM states: IDLE, BUSY, FLUSH.
- IDLE: if any reqValid is high at edge t, pick the winner by policy.
  - Register the winner's fields into io_mem_*. An IFU grant forces size=2, wen=0, wdata=0, wmask=0.
  - Set owner; io_mem_reqValid=1 from t+1; go to BUSY.
  - Grant latency is 1 cycle.
- BUSY: io_mem_reqValid and io_mem_* are held constant.
  - The owner's respValid = io_mem_respValid, combinational with zero latency; rdata passes through from io_mem_rdata; err=0.
  - On io_mem_respValid: io_mem_reqValid drops at the next edge, state returns to IDLE, and rr_last=owner.
  - The non-owner's respValid is never asserted.
- Timeout (TIMEOUT_CYCLES>0): the counter increments each BUSY cycle without a response and clears on leaving BUSY.
  - When the counter equals TIMEOUT_CYCLES-1 and there is still no response, the owner gets respValid=1, err=1, rdata=ERR_RDATA in that cycle.
  - io_mem_reqValid then drops and state goes to FLUSH.
  - A response arriving in the same cycle as the timeout wins: normal response, err=0.
- FLUSH: io_mem_reqValid=0; both respValid outputs are held at 0.
  - The next io_mem_respValid is swallowed, then state returns to IDLE.
  - A missing late response blocks the arbiter indefinitely; this is accepted.
- Priority when both requesters are valid in IDLE:
  - LSU_FIRST=1: LSU wins.
  - LSU_FIRST=0: the requester other than rr_last wins.
- Requests arriving while BUSY or FLUSH wait; no queueing inside the block.
- io_mem_respValid while IDLE: ignored.
- Reset asserted mid-transaction returns to IDLE immediately; downstream must also be reset.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, BUSY, FLUSH};
  - the owner enum {OWN_IFU, OWN_LSU};
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - a mem_req_t struct of addr/size/wen/wdata/wmask.
- One natural sub-module: mem_port_watchdog (counter plus timeout flag; inputs busy, resp; output expire).

Test Plan:
1. IFU only: ifu_addr=0x8000_0000, mem responds 3 cycles after reqValid with 0x0000_0413 -> mem_reqValid at t+1, size=2, wen=0; ifu_respValid one cycle, rdata=0x0000_0413, err=0; lsu_respValid stays 0.
2. Simultaneous requests, LSU_FIRST=1: lsu store addr=0x1000, wdata=0xAABBCCDD, wmask=4'b1111; IFU waits -> LSU fields appear first; after its response IFU is granted in the next IDLE cycle.
3. LSU_FIRST=0, both requesters held valid for 4 transactions -> grant order IFU, LSU, IFU, LSU.
4. TIMEOUT_CYCLES=8, no mem response -> in the 8th BUSY cycle owner sees respValid=1, err=1, rdata=0; state goes to FLUSH; a late mem_respValid 5 cycles later is swallowed; the next request is granted normally.
5. Response in the exact timeout cycle -> err=0, real rdata delivered, no FLUSH.
6. Reset asserted during BUSY -> next cycle all outputs are 0 and state is IDLE; a new IFU request is granted 1 cycle after reset drops.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IFU/LSU memory port arbiter: FSM states, owner tags,
// access-size codes and the registered downstream request record.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFlush
  } state_e;

  typedef enum logic {
    OwnIfu,
    OwnLsu
  } owner_e;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  // Instruction fetches are always aligned word reads.
  function automatic mem_req_t ifu_req(input logic [31:0] addr);
    mem_req_t r;
    r.addr  = addr;
    r.size  = SzWord;
    r.wen   = 1'b0;
    r.wdata = '0;
    r.wmask = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_watchdog.sv
// Response watchdog: counts BUSY cycles without a response and flags expiry
// in the last allowed cycle. TIMEOUT_CYCLES of 0 disables it.
module mem_port_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic busy,
  input  logic resp,
  output logic expire
);

  localparam bit          Enable = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CntW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = Enable ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    // A response in the final cycle wins over the timeout.
    expire = Enable && busy && !resp && (cnt_q == Last);
    if (Enable && busy && !resp && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between the IFU and the LSU with
// fixed-LSU or round-robin priority and a response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit          LSU_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  output logic        io_ifu_err,

  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        io_lsu_err,

  output logic        io_mem_reqValid,
  output logic [31:0] io_mem_addr,
  output logic [1:0]  io_mem_size,
  output logic        io_mem_wen,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wmask,
  input  logic        io_mem_respValid,
  input  logic [31:0] io_mem_rdata
);

  state_e   state_q, state_d;
  owner_e   owner_q, owner_d;
  owner_e   rr_last_q, rr_last_d;
  mem_req_t req_q, req_d;
  logic     mem_valid_q, mem_valid_d;

  mem_req_t    lsu_req;
  logic        grant_lsu;
  logic        expire;
  logic        resp_fire;
  logic [31:0] resp_data;
  logic        resp_err;

  mem_port_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .busy  (state_q == StBusy),
    .resp  (io_mem_respValid),
    .expire(expire)
  );

  assign lsu_req = '{
    addr:  io_lsu_addr,
    size:  io_lsu_size,
    wen:   io_lsu_wen,
    wdata: io_lsu_wdata,
    wmask: io_lsu_wmask
  };

  always_comb begin
    if (!io_lsu_reqValid) begin
      grant_lsu = 1'b0;
    end else if (!io_ifu_reqValid) begin
      grant_lsu = 1'b1;
    end else if (LSU_FIRST) begin
      grant_lsu = 1'b1;
    end else begin
      // Round-robin: whoever was not served last goes next.
      grant_lsu = (rr_last_q == OwnIfu);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnIfu;
      rr_last_q   <= OwnLsu;
      req_q       <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      req_q       <= req_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    req_d       = req_q;
    mem_valid_d = mem_valid_q;
    case (state_q)
      StIdle: begin
        if (io_ifu_reqValid || io_lsu_reqValid) begin
          state_d     = StBusy;
          mem_valid_d = 1'b1;
          owner_d     = grant_lsu ? OwnLsu : OwnIfu;
          req_d       = grant_lsu ? lsu_req : ifu_req(io_ifu_addr);
        end
      end
      StBusy: begin
        if (io_mem_respValid) begin
          state_d     = StIdle;
          mem_valid_d = 1'b0;
          rr_last_d   = owner_q;
        end else if (expire) begin
          // The late response still has to be absorbed before reuse.
          state_d     = StFlush;
          mem_valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (io_mem_respValid) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    io_mem_reqValid = mem_valid_q;
    io_mem_addr     = req_q.addr;
    io_mem_size     = req_q.size;
    io_mem_wen      = req_q.wen;
    io_mem_wdata    = req_q.wdata;
    io_mem_wmask    = req_q.wmask;

    resp_fire = (state_q == StBusy) && (io_mem_respValid || expire);
    resp_data = io_mem_respValid ? io_mem_rdata : ERR_RDATA;
    resp_err  = !io_mem_respValid;

    io_ifu_respValid = resp_fire && (owner_q == OwnIfu);
    io_ifu_rdata     = io_ifu_respValid ? resp_data : '0;
    io_ifu_err       = io_ifu_respValid && resp_err;

    io_lsu_respValid = resp_fire && (owner_q == OwnLsu);
    io_lsu_rdata     = io_lsu_respValid ? resp_data : '0;
    io_lsu_err       = io_lsu_respValid && resp_err;
  end

  a_single_resp: assert property (@(posedge clock) disable iff (reset)
    !(io_ifu_respValid && io_lsu_respValid));

  a_req_iff_busy: assert property (@(posedge clock) disable iff (reset)
    io_mem_reqValid == (state_q == StBusy));

  a_req_stable: assert property (@(posedge clock) disable iff (reset)
    (state_q == StBusy && !io_mem_respValid && !expire) |=> $stable(req_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one LSU-first instance and one round-robin
// instance, table-driven grants plus hand-written timeout/reset sequences.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        ifu_v, lsu_v, mem_rv, rr_ifu_v, rr_lsu_v, rr_mem_rv;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;

  logic        lf_ifu_rv, lf_ifu_err, lf_lsu_rv, lf_lsu_err, lf_mem_v, lf_mem_wen;
  logic [31:0] lf_ifu_rdata, lf_lsu_rdata, lf_mem_addr, lf_mem_wdata;
  logic [1:0]  lf_mem_size;
  logic [3:0]  lf_mem_wmask;

  logic        rr_ifu_rv, rr_ifu_err, rr_lsu_rv, rr_lsu_err, rr_mem_v, rr_mem_wen;
  logic [31:0] rr_ifu_rdata, rr_lsu_rdata, rr_mem_addr, rr_mem_wdata;
  logic [1:0]  rr_mem_size;
  logic [3:0]  rr_mem_wmask;

  mem_port_arbiter #(.LSU_FIRST(1'b1), .TIMEOUT_CYCLES(8)) dut_lf (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_v), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(lf_ifu_rv), .io_ifu_rdata(lf_ifu_rdata), .io_ifu_err(lf_ifu_err),
    .io_lsu_reqValid(lsu_v), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(lf_lsu_rv), .io_lsu_rdata(lf_lsu_rdata), .io_lsu_err(lf_lsu_err),
    .io_mem_reqValid(lf_mem_v), .io_mem_addr(lf_mem_addr), .io_mem_size(lf_mem_size),
    .io_mem_wen(lf_mem_wen), .io_mem_wdata(lf_mem_wdata), .io_mem_wmask(lf_mem_wmask),
    .io_mem_respValid(mem_rv), .io_mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LSU_FIRST(1'b0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(rr_ifu_v), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(rr_ifu_rv), .io_ifu_rdata(rr_ifu_rdata), .io_ifu_err(rr_ifu_err),
    .io_lsu_reqValid(rr_lsu_v), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(rr_lsu_rv), .io_lsu_rdata(rr_lsu_rdata), .io_lsu_err(rr_lsu_err),
    .io_mem_reqValid(rr_mem_v), .io_mem_addr(rr_mem_addr), .io_mem_size(rr_mem_size),
    .io_mem_wen(rr_mem_wen), .io_mem_wdata(rr_mem_wdata), .io_mem_wmask(rr_mem_wmask),
    .io_mem_respValid(rr_mem_rv), .io_mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t q_lf[$];
  exp_t q_rr[$];
  exp_t e_lf, e_rr;

  typedef struct {
    bit          ifu_v;
    bit          lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic [1:0]  size;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    bit          exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    bit          exp_lsu;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_lf_mem(input string nm, input logic v, input logic [31:0] a,
                              input logic [1:0] s, input logic w, input logic [31:0] d,
                              input logic [3:0] m);
    check(nm, {lf_mem_v, lf_mem_addr, lf_mem_size, lf_mem_wen, lf_mem_wdata, lf_mem_wmask},
          {v, a, s, w, d, m});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Response scoreboards: every response pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (lf_ifu_rv || lf_lsu_rv) begin
      if (q_lf.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lf_unexpected_resp: got ifu=%0b lsu=%0b, expected none", lf_ifu_rv,
                 lf_lsu_rv);
      end else begin
        e_lf = q_lf.pop_front();
        check("lf_resp_sel", {lf_lsu_rv, lf_ifu_rv}, e_lf.lsu ? 2'b10 : 2'b01);
        check("lf_resp_rdata", e_lf.lsu ? lf_lsu_rdata : lf_ifu_rdata, e_lf.rdata);
        check("lf_resp_err", e_lf.lsu ? lf_lsu_err : lf_ifu_err, e_lf.err);
      end
    end
  end

  always @(negedge clock) begin
    if (rr_ifu_rv || rr_lsu_rv) begin
      if (q_rr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rr_unexpected_resp: got ifu=%0b lsu=%0b, expected none", rr_ifu_rv,
                 rr_lsu_rv);
      end else begin
        e_rr = q_rr.pop_front();
        check("rr_resp_sel", {rr_lsu_rv, rr_ifu_rv}, e_rr.lsu ? 2'b10 : 2'b01);
        check("rr_resp_rdata", e_rr.lsu ? rr_lsu_rdata : rr_ifu_rdata, e_rr.rdata);
        check("rr_resp_err", e_rr.lsu ? rr_lsu_err : rr_ifu_err, e_rr.err);
      end
    end
  end

  initial begin
    vecs[0] = '{1, 0, 32'h8000_0000, 32'h0, 2'd0, 1, 32'hFFFF_FFFF, 4'h1, 32'h0000_0413, 3,
                32'h8000_0000, 2'd2, 0, 32'h0, 4'h0, 0};
    vecs[1] = '{0, 1, 32'h0, 32'h0000_2001, 2'd0, 0, 32'h0, 4'h2, 32'h0000_00AB, 0,
                32'h0000_2001, 2'd0, 0, 32'h0, 4'h2, 1};
    vecs[2] = '{0, 1, 32'h0, 32'h0000_3002, 2'd1, 1, 32'h0000_BEEF, 4'hC, 32'h0, 2,
                32'h0000_3002, 2'd1, 1, 32'h0000_BEEF, 4'hC, 1};
    vecs[3] = '{1, 0, 32'h8000_0100, 32'h0000_7777, 2'd1, 1, 32'h1234_5678, 4'hF,
                32'h0000_0093, 5, 32'h8000_0100, 2'd2, 0, 32'h0, 4'h0, 0};
    vecs[4] = '{0, 1, 32'h0, 32'h0000_1000, 2'd2, 1, 32'hCAFE_F00D, 4'hF, 32'h0, 1,
                32'h0000_1000, 2'd2, 1, 32'hCAFE_F00D, 4'hF, 1};

    ifu_v = 0; lsu_v = 0; mem_rv = 0; rr_ifu_v = 0; rr_lsu_v = 0; rr_mem_rv = 0;
    ifu_addr = 0; lsu_addr = 0; lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_rdata = 0;
    repeat (3) step();

    check_lf_mem("reset_lf_mem", 0, 0, 0, 0, 0, 0);
    check("reset_lf_resp", {lf_ifu_rv, lf_ifu_rdata, lf_ifu_err, lf_lsu_rv, lf_lsu_rdata,
          lf_lsu_err}, 0);
    check("reset_rr_mem", {rr_mem_v, rr_mem_addr, rr_mem_size, rr_mem_wen, rr_mem_wdata,
          rr_mem_wmask}, 0);
    reset = 0;

    // Single-requester grants on the LSU-first instance.
    for (int i = 0; i < NV; i++) begin
      ifu_v = vecs[i].ifu_v; lsu_v = vecs[i].lsu_v; ifu_addr = vecs[i].ifu_addr;
      lsu_addr = vecs[i].lsu_addr; lsu_size = vecs[i].size; lsu_wen = vecs[i].wen;
      lsu_wdata = vecs[i].wdata; lsu_wmask = vecs[i].wmask; mem_rdata = 32'hDEAD_0000;
      step();
      check_lf_mem($sformatf("v%0d_grant", i), 1, vecs[i].exp_addr, vecs[i].exp_size,
                   vecs[i].exp_wen, vecs[i].exp_wdata, vecs[i].exp_wmask);
      for (int k = 0; k < vecs[i].lat; k++) begin
        step();
        check_lf_mem($sformatf("v%0d_hold", i), 1, vecs[i].exp_addr, vecs[i].exp_size,
                     vecs[i].exp_wen, vecs[i].exp_wdata, vecs[i].exp_wmask);
      end
      q_lf.push_back('{vecs[i].exp_lsu, vecs[i].rdata, 1'b0});
      mem_rv = 1; mem_rdata = vecs[i].rdata;
      step();
      mem_rv = 0; ifu_v = 0; lsu_v = 0;
      check($sformatf("v%0d_release", i), lf_mem_v, 0);
      check($sformatf("v%0d_sb_empty", i), q_lf.size(), 0);
    end

    // Simultaneous requests: LSU first, IFU in the following IDLE cycle.
    ifu_v = 1; ifu_addr = 32'h8000_0000;
    lsu_v = 1; lsu_addr = 32'h1000; lsu_size = 2; lsu_wen = 1; lsu_wdata = 32'hAABB_CCDD;
    lsu_wmask = 4'hF;
    step();
    check_lf_mem("t2_lsu_grant", 1, 32'h1000, 2, 1, 32'hAABB_CCDD, 4'hF);
    q_lf.push_back('{1'b1, 32'h0, 1'b0});
    mem_rv = 1; mem_rdata = 0;
    step();
    mem_rv = 0; lsu_v = 0;
    check("t2_idle_gap", lf_mem_v, 0);
    step();
    check_lf_mem("t2_ifu_grant", 1, 32'h8000_0000, 2, 0, 0, 0);
    q_lf.push_back('{1'b0, 32'h0000_0413, 1'b0});
    mem_rv = 1; mem_rdata = 32'h0000_0413;
    step();
    mem_rv = 0; ifu_v = 0;
    check("t2_release", lf_mem_v, 0);
    check("t2_sb_empty", q_lf.size(), 0);

    // Timeout, flush of the late response, then a normal grant.
    ifu_v = 1; ifu_addr = 32'h8000_0040; mem_rdata = 32'h5555_5555;
    step();
    check_lf_mem("t4_grant", 1, 32'h8000_0040, 2, 0, 0, 0);
    repeat (7) step();
    q_lf.push_back('{1'b0, 32'h0, 1'b1});
    step();
    ifu_addr = 32'h8000_0044;
    check("t4_sb_empty", q_lf.size(), 0);
    check("t4_flush_noreq", lf_mem_v, 0);
    repeat (4) begin
      step();
      check("t4_flush_hold", lf_mem_v, 0);
    end
    mem_rv = 1; mem_rdata = 32'h0000_9999;
    step();
    mem_rv = 0;
    check("t4_idle_after_flush", lf_mem_v, 0);
    step();
    check_lf_mem("t4_regrant", 1, 32'h8000_0044, 2, 0, 0, 0);
    q_lf.push_back('{1'b0, 32'h0000_0517, 1'b0});
    mem_rv = 1; mem_rdata = 32'h0000_0517;
    step();
    mem_rv = 0; ifu_v = 0;
    check("t4_release", lf_mem_v, 0);
    check("t4_sb_empty2", q_lf.size(), 0);

    // Response in the exact timeout cycle wins; no flush follows.
    lsu_v = 1; lsu_addr = 32'h5000; lsu_size = 2; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 4'hF;
    step();
    check_lf_mem("t5_grant", 1, 32'h5000, 2, 0, 0, 4'hF);
    repeat (7) step();
    q_lf.push_back('{1'b1, 32'h1234_5678, 1'b0});
    mem_rv = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_rv = 0; lsu_v = 0;
    check("t5_release", lf_mem_v, 0);
    ifu_v = 1; ifu_addr = 32'h8000_0080;
    step();
    check_lf_mem("t5_no_flush_grant", 1, 32'h8000_0080, 2, 0, 0, 0);
    q_lf.push_back('{1'b0, 32'h0000_0013, 1'b0});
    mem_rv = 1; mem_rdata = 32'h0000_0013;
    step();
    mem_rv = 0; ifu_v = 0;
    check("t5_sb_empty", q_lf.size(), 0);

    // Reset in the middle of a transaction.
    lsu_v = 1; lsu_addr = 32'h6000; lsu_size = 1; lsu_wen = 1; lsu_wdata = 32'h0BAD_F00D;
    lsu_wmask = 4'h3;
    step();
    check_lf_mem("t6_grant", 1, 32'h6000, 1, 1, 32'h0BAD_F00D, 4'h3);
    step();
    reset = 1; lsu_v = 0; mem_rdata = 32'h0000_7777;
    step();
    check_lf_mem("t6_reset_mem", 0, 0, 0, 0, 0, 0);
    check("t6_reset_resp", {lf_ifu_rv, lf_ifu_rdata, lf_ifu_err, lf_lsu_rv, lf_lsu_rdata,
          lf_lsu_err}, 0);
    reset = 0; ifu_v = 1; ifu_addr = 32'h8000_00C0;
    step();
    check_lf_mem("t6_post_reset_grant", 1, 32'h8000_00C0, 2, 0, 0, 0);
    q_lf.push_back('{1'b0, 32'h0000_0033, 1'b0});
    mem_rv = 1; mem_rdata = 32'h0000_0033;
    step();
    mem_rv = 0; ifu_v = 0;
    check("t6_sb_empty", q_lf.size(), 0);

    // Round-robin instance with both requesters held valid.
    ifu_addr = 32'h8000_0000; lsu_addr = 32'h1000; lsu_size = 2; lsu_wen = 0; lsu_wdata = 0;
    lsu_wmask = 4'hF;
    rr_ifu_v = 1; rr_lsu_v = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t3_grant%0d_valid", i), rr_mem_v, 1);
      check($sformatf("t3_grant%0d_addr", i), rr_mem_addr,
            i[0] ? 32'h0000_1000 : 32'h8000_0000);
      q_rr.push_back('{i[0], 32'h100 + 32'(i), 1'b0});
      rr_mem_rv = 1; mem_rdata = 32'h100 + 32'(i);
      step();
      rr_mem_rv = 0;
      if (i == 3) begin
        rr_ifu_v = 0; rr_lsu_v = 0;
      end
      check($sformatf("t3_release%0d", i), rr_mem_v, 0);
    end
    check("t3_sb_empty", q_rr.size(), 0);
    step();
    check("rr_idle_end", rr_mem_v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
